// File: rtl/fx2_rx_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fx2_rx_unpack
// Description : Reads 16-bit words from an FX2 slave-FIFO OUT endpoint and
//               pairs them into complex samples (even word = real, odd word =
//               imag) for a streaming FFT core with valid/ready handshake.
//               fft_last marks sample 2^NPOINT-1 of each frame.
//               Optional macro FX2_RX_BYTESWAP_EN byte-swaps every captured
//               word (DW must then be 16).
// Revision    : 1.0 - initial release
// ============================================================================
module fx2_rx_unpack #(
    parameter int NPOINT = 3,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fx2_flaga,
    input  logic [DW-1:0] fx2_db_in,
    output logic          fx2_slcs_n,
    output logic          fx2_sloe_n,
    output logic          fx2_slrd_n,
    output logic [1:0]    fx2_a,
    output logic          fft_valid,
    input  logic          fft_ready,
    output logic [DW-1:0] fft_re,
    output logic [DW-1:0] fft_im,
    output logic          fft_last
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_OE   = 2'd1;
    localparam logic [1:0] c_ST_READ = 2'd2;
    localparam logic [1:0] c_ST_HOLD = 2'd3;

    localparam logic [NPOINT-1:0] c_LAST_IDX = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_phase;     // parity of the next word to be consumed
    logic              r_cap_pend;  // a word was strobed last edge, capture now
    logic              r_cap_odd;   // the pending word is the imag half
    logic [DW-1:0]     r_re_hold;   // real half waiting for its partner
    logic [DW-1:0]     r_re;
    logic [DW-1:0]     r_im;
    logic              r_valid;
    logic [NPOINT-1:0] r_cnt;
    logic [DW-1:0]     w_word;
    logic              w_rd;
    logic              w_accept;

`ifdef FX2_RX_BYTESWAP_EN
    assign w_word = {fx2_db_in[7:0], fx2_db_in[15:8]};
`else
    assign w_word = fx2_db_in;
`endif

    assign w_accept = r_valid & fft_ready;

    // Next-state and FX2 strobe decode; a read is only issued when the
    // output register can take a completed sample by the time it lands.
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        fx2_slcs_n  = 1'b1;
        fx2_sloe_n  = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                if (fx2_flaga) w_state_nxt = c_ST_OE;
            end
            c_ST_OE: begin
                fx2_slcs_n  = 1'b0;
                fx2_sloe_n  = 1'b0;
                w_state_nxt = c_ST_READ;
            end
            c_ST_READ: begin
                fx2_slcs_n = 1'b0;
                fx2_sloe_n = 1'b0;
                w_rd       = fx2_flaga & (~r_valid | fft_ready);
                if (r_valid && !fft_ready)
                    w_state_nxt = c_ST_HOLD;
                else if (!fx2_flaga && !r_phase && !r_valid && !r_cap_pend)
                    w_state_nxt = c_ST_IDLE;
            end
            c_ST_HOLD: begin
                fx2_slcs_n = 1'b0;
                fx2_sloe_n = 1'b0;
                if (w_accept) w_state_nxt = c_ST_READ;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign fx2_slrd_n = ~w_rd;
    assign fx2_a      = 2'b00;
    assign fft_valid  = r_valid;
    assign fft_re     = r_re;
    assign fft_im     = r_im;
    assign fft_last   = r_valid & (r_cnt == c_LAST_IDX);

    // State register plus word pairing, output register and sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_phase    <= 1'b0;
            r_cap_pend <= 1'b0;
            r_cap_odd  <= 1'b0;
            r_re_hold  <= '0;
            r_re       <= '0;
            r_im       <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cap_pend <= w_rd;
            if (w_rd) begin
                r_cap_odd <= r_phase;
                r_phase   <= ~r_phase;
            end
            if (w_accept) begin
                r_valid <= 1'b0;
                r_cnt   <= r_cnt + 1'b1;
            end
            // Load wins over a same-cycle accept: the slot was just freed.
            if (r_cap_pend) begin
                if (r_cap_odd) begin
                    r_re    <= r_re_hold;
                    r_im    <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_re_hold <= w_word;
                end
            end
        end
    end

endmodule
`default_nettype wire
